// File: rtl/reg_bank_pkg.sv
// Shared constants for the MIPS-style register file and its neighbours (destination select).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_bank_pkg;

    // Default geometry of the register file.
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_SP_RESET = 227;

    // Architecturally special register indices.
    localparam logic [4:0] REG_ZERO = 5'd0;   // hard-wired zero
    localparam logic [4:0] REG_SP   = 5'd29;  // stack pointer, non-zero reset value
    localparam logic [4:0] REG_RA   = 5'd31;  // link register written by jal

    // True when a write to this index may change architectural state.
    function automatic logic is_writable(input logic [4:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage : reg_bank_pkg

// File: rtl/reg_bank_read_port.sv
// One combinational read port: array index mux, register-0 force-zero, optional write-through bypass.
// Latency: zero cycles, purely combinational from rd_addr / bypass inputs to rd_dat.
// Backpressure: none; always returns data. Bypass compiled in only with REG_BANK_BYPASS_EN.
module reg_bank_read_port
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               byp_vld,
    input  logic [ADDR_W-1:0]                  byp_addr,
    input  logic [DATA_W-1:0]                  byp_dat,
    output logic [DATA_W-1:0]                  rd_dat
);

`ifndef REG_BANK_BYPASS_EN
    // Without forwarding the in-flight write is invisible until the clock edge.
    logic unused_byp;
    assign unused_byp = ^{byp_vld, byp_addr, byp_dat};
`endif

    // Select stored word, optionally override with the in-flight write, then force index 0 to zero.
    always_comb begin
        rd_dat = regs[rd_addr];
`ifdef REG_BANK_BYPASS_EN
        if (byp_vld && (byp_addr == rd_addr)) begin
            rd_dat = byp_dat;
        end
`endif
        // Applied last so a forwarded write to index 0 can never leak out.
        if (rd_addr == '0) begin
            rd_dat = '0;
        end
    end

endmodule : reg_bank_read_port

// File: rtl/reg_bank.sv
// 32x32 register file: one synchronous write port, two combinational read ports; optional REG_BANK_BYPASS_EN.
// Latency: reads zero cycles; writes visible the cycle after the write edge (same cycle when bypassed).
// Backpressure: none; a write is accepted every cycle RegWrite is high, reset discards it.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(DEF_SP_RESET)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int unsigned NREG   = 2**ADDR_W;
    localparam int unsigned SP_IDX = int'(REG_SP);

    typedef logic [NREG-1:0][DATA_W-1:0] regs_t;

    // Reset image: everything zero except the stack pointer.
    function automatic regs_t reset_image();
        regs_t img;
        img         = '0;
        img[SP_IDX] = SP_RESET;
        return img;
    endfunction

    regs_t regs_q;
    regs_t regs_d;
    logic  wr_en;

    // A write only counts when enabled and not aimed at the hard-wired zero register.
    assign wr_en = RegWrite && is_writable(5'(WriteReg));

    // Next-state of the array: single-entry write decode, entry 0 pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteReg] = WriteData;
        end
        regs_d[0] = '0;
    end

    // Register array; asynchronous reset dominates any write in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= reset_image();
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding qualifier: a live write, outside reset.
    logic byp_vld;
    assign byp_vld = RegWrite && reset;

    reg_bank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .regs     (regs_q),
        .rd_addr  (ReadReg1),
        .byp_vld  (byp_vld),
        .byp_addr (WriteReg),
        .byp_dat  (WriteData),
        .rd_dat   (ReadData1)
    );

    reg_bank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .regs     (regs_q),
        .rd_addr  (ReadReg2),
        .byp_vld  (byp_vld),
        .byp_addr (WriteReg),
        .byp_dat  (WriteData),
        .rd_dat   (ReadData2)
    );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic against an array model.
// Latency: model expects zero-cycle reads and next-cycle write visibility.
// Backpressure: none exercised; the bank accepts every cycle.
module tb_reg_bank;
    import reg_bank_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
    localparam logic [DW-1:0] SPV = 32'd227;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] ReadReg1;
    logic [AW-1:0] ReadReg2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    int checks = 0;
    int errors = 0;

    // Architectural model: plain array of register contents.
    logic [DW-1:0] mdl [NR];

    reg_bank #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .SP_RESET (SPV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = (i == 29) ? SPV : '0;
    endtask

    // What a read port must show right now, given the model and the current write inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REG_BANK_BYPASS_EN
        if (reset === 1'b1 && RegWrite === 1'b1 && WriteReg == a) return WriteData;
`endif
        return mdl[a];
    endfunction

    // Advance one clock: commit the pending write into the model at the edge, return at the next negedge.
    task automatic clk_edge();
        @(posedge clk);
        if (reset === 1'b1 && RegWrite === 1'b1 && WriteReg != 0) mdl[WriteReg] = WriteData;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd5;
        model_reset();
        #1;
        checks++;
        if (ReadData1 !== 32'd227) begin
            errors++;
            $display("FAIL reset_sp: got %h required %h", ReadData1, 32'd227);
        end
        checks++;
        if (ReadData2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_r5: got %h required %h", ReadData2, 32'd0);
        end
        for (int i = 0; i < NR; i++) begin
            ReadReg1 = AW'(i);
            ReadReg2 = AW'(NR - 1 - i);
            #1;
            checks++;
            if (ReadData1 !== mdl[i]) begin
                errors++;
                $display("FAIL reset_all_p1 idx %0d: got %h required %h", i, ReadData1, mdl[i]);
            end
            checks++;
            if (ReadData2 !== mdl[NR-1-i]) begin
                errors++;
                $display("FAIL reset_all_p2 idx %0d: got %h required %h", NR - 1 - i, ReadData2, mdl[NR-1-i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd8;
        clk_edge();
        RegWrite = 1'b0; WriteData = 32'h1;
        #1;
        checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: got %h required %h", ReadData1, 32'hDEADBEEF);
        end
        clk_edge();
        #1;
        checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_disabled: got %h required %h", ReadData1, 32'hDEADBEEF);
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        checks++;
        if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
            errors++;
            $display("FAIL zero_pre_edge: got %h/%h required 0/0", ReadData1, ReadData2);
        end
        clk_edge();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
            errors++;
            $display("FAIL zero_post_edge: got %h/%h required 0/0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_link();
        RegWrite = 1'b1; WriteReg = 5'd30; WriteData = 32'h1234_5678;
        clk_edge();
        WriteReg = REG_RA; WriteData = 32'h0000_0040;
        clk_edge();
        RegWrite = 1'b0; ReadReg2 = 5'd31; ReadReg1 = 5'd30;
        #1;
        checks++;
        if (ReadData2 !== 32'h40) begin
            errors++;
            $display("FAIL link_r31: got %h required %h", ReadData2, 32'h40);
        end
        checks++;
        if (ReadData1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL link_r30: got %h required %h", ReadData1, 32'h1234_5678);
        end
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] pre_exp;
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'd5;
        clk_edge();
        WriteData = 32'd7; ReadReg1 = 5'd9;
`ifdef REG_BANK_BYPASS_EN
        pre_exp = 32'd7;
`else
        pre_exp = 32'd5;
`endif
        #1;
        checks++;
        if (ReadData1 !== pre_exp) begin
            errors++;
            $display("FAIL rdw_pre_edge: got %h required %h", ReadData1, pre_exp);
        end
        clk_edge();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'd7) begin
            errors++;
            $display("FAIL rdw_post_edge: got %h required %h", ReadData1, 32'd7);
        end
    endtask

    task automatic test_reset_mid_op();
        RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'hA5; ReadReg1 = 5'd12; ReadReg2 = 5'd29;
        clk_edge();
        #1;
        checks++;
        if (ReadData1 !== 32'hA5) begin
            errors++;
            $display("FAIL midrst_setup: got %h required %h", ReadData1, 32'hA5);
        end
        WriteData = 32'h5A;
        reset = 1'b0;
        model_reset();
        clk_edge();
        reset = 1'b1;
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'd0) begin
            errors++;
            $display("FAIL midrst_r12: got %h required %h", ReadData1, 32'd0);
        end
        checks++;
        if (ReadData2 !== 32'd227) begin
            errors++;
            $display("FAIL midrst_sp: got %h required %h", ReadData2, 32'd227);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        for (int n = 0; n < 400; n++) begin
            RegWrite  = 1'($urandom_range(0, 1));
            WriteReg  = AW'($urandom);
            WriteData = $urandom;
            ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom);
            ReadReg2  = ($urandom_range(0, 4) == 0) ? ReadReg1 : AW'($urandom);
            #1;
            e1 = exp_rd(ReadReg1);
            e2 = exp_rd(ReadReg2);
            checks++;
            if (ReadData1 !== e1) begin
                errors++;
                $display("FAIL rand_p1 iter %0d idx %0d: got %h required %h", n, ReadReg1, ReadData1, e1);
            end
            checks++;
            if (ReadData2 !== e2) begin
                errors++;
                $display("FAIL rand_p2 iter %0d idx %0d: got %h required %h", n, ReadReg2, ReadData2, e2);
            end
            clk_edge();
        end
        RegWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_link();
        test_read_during_write();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_bank
